// File: rtl/fir_mc_pkg.sv
// fir_mc_pkg: shared types and helpers for the
// multichannel time-multiplexed FIR filter.
package fir_mc_pkg;

  localparam int MAX_W = 128;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_e;

  typedef struct packed {
    logic signed [MAX_W-1:0] val;
    logic                    sat;
  } sr_t;

  // channel-select width, never below one bit
  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // shift right by s with round-half-up, then clip to ow bits signed
  function automatic sr_t sat_round(
    input logic signed [MAX_W-1:0] v,
    input int                      s,
    input int                      ow
  );
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    sr_t o;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    r = v;
    if (s > 0) r = (v + (one <<< (s - 1))) >>> s;
    hi = (one <<< (ow - 1)) - one;
    lo = -(one <<< (ow - 1));
    o.val = r;
    o.sat = 1'b0;
    if (r > hi) begin
      o.val = hi;
      o.sat = 1'b1;
    end else if (r < lo) begin
      o.val = lo;
      o.sat = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/fir_mc_coeff_bank.sv
// fir_mc_coeff_bank: double-buffered coefficient store.
// Shadow takes writes any time; active changes only on swap.
module fir_mc_coeff_bank
  import fir_mc_pkg::*;
#(
  parameter int N       = 32,
  parameter int COEFF_W = 32,
  localparam int TW     = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_en_i,
  input  logic [TW-1:0]      addr_i,
  input  logic [COEFF_W-1:0] data_i,
  input  logic               swap_req_i,
  input  logic               swap_ok_i,
  input  logic [TW-1:0]      rd_addr_i,
  output logic [COEFF_W-1:0] rd_data_o
);

  logic [COEFF_W-1:0] shadow_q [N];
  logic [COEFF_W-1:0] shadow_d [N];
  logic [COEFF_W-1:0] active_q [N];
  logic               pend_q;
  logic               pend_d;
  logic               swap_now;

  // merge this cycle's write so a same-cycle swap copies it
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i && (int'(addr_i) < N))
      shadow_d[addr_i] = data_i;
  end

  assign swap_now = (pend_q || swap_req_i) && swap_ok_i;
  assign pend_d   = (pend_q || swap_req_i) && !swap_ok_i;

  // shadow tracks writes; active copies shadow on a swap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pend_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (swap_now) active_q <= shadow_d;
      pend_q <= pend_d;
    end
  end

  assign rd_data_o = active_q[rd_addr_i];

endmodule

// File: rtl/fir_mc.sv
// fir_mc: N-tap, CH-channel FIR sharing one MAC.
// One sample per N cycles, output N edges after accept.
module fir_mc
  import fir_mc_pkg::*;
#(
  parameter int N       = 32,
  parameter int CH      = 2,
  parameter int IN_W    = 32,
  parameter int COEFF_W = 32,
  parameter int OUT_W   = 32,
  parameter int R_IN    = 31,
  parameter int R_COEFF = 31,
  parameter int R_OUT   = 31,
  parameter int ACC_W   = IN_W + COEFF_W + $clog2(N),
  localparam int CW     = ch_w(CH),
  localparam int TW     = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               valid_in,
  input  logic [CW-1:0]      ch_in,
  input  logic [IN_W-1:0]    data_in,
  output logic               ready_in,
  input  logic               coeff_wr_en,
  input  logic [TW-1:0]      coeff_addr,
  input  logic [COEFF_W-1:0] coeff_data,
  input  logic               coeff_swap,
  output logic [OUT_W-1:0]   data_out,
  output logic [CW-1:0]      ch_out,
  output logic               valid_out,
  output logic               sat,
  output logic               overrun
);

  localparam int PW = IN_W + COEFF_W;
  localparam int S  = R_IN + R_COEFF - R_OUT;

  state_e                  state_q;
  logic [TW-1:0]           tap_q;
  logic [CW-1:0]           chs_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [TW-1:0]           head_q [CH];
  logic signed [IN_W-1:0]  x_q [CH][N];

  logic                    last;
  logic                    accept;
  logic                    drop;
  logic                    swap_ok;
  logic [TW-1:0]           head;
  logic [TW-1:0]           rd_idx;
  logic [TW-1:0]           wr_idx;
  logic signed [IN_W-1:0]  xs;
  logic [COEFF_W-1:0]      cf;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] sum;
  sr_t                     res;
  logic                    unused_hi;

  assign last     = (state_q == MAC) && (tap_q == TW'(N - 1));
  assign ready_in = (state_q == IDLE) || last;
  assign accept   = valid_in && ready_in && (int'(ch_in) < CH);
  assign drop     = valid_in && !accept;
  assign swap_ok  = ready_in;

  assign head   = head_q[chs_q];
  assign rd_idx = (tap_q > head)
                ? TW'(int'(head) + N - int'(tap_q))
                : head - tap_q;
  assign wr_idx = (head_q[ch_in] == TW'(N - 1))
                ? '0
                : head_q[ch_in] + 1'b1;

  assign xs   = x_q[chs_q][rd_idx];
  assign prod = PW'(xs) * PW'($signed(cf));
  assign sum  = acc_q + ACC_W'(prod);
  assign res  = sat_round(MAX_W'(sum), S, OUT_W);

  assign unused_hi = ^res.val[MAX_W-1:OUT_W];

  fir_mc_coeff_bank #(
    .N       (N),
    .COEFF_W (COEFF_W)
  ) u_bank (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en_i    (coeff_wr_en),
    .addr_i     (coeff_addr),
    .data_i     (coeff_data),
    .swap_req_i (coeff_swap),
    .swap_ok_i  (swap_ok),
    .rd_addr_i  (tap_q),
    .rd_data_o  (cf)
  );

  // per-channel circular delay lines, newest at head
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CH; c++) begin
        head_q[c] <= '0;
        for (int i = 0; i < N; i++)
          x_q[c][i] <= '0;
      end
    end else if (accept) begin
      x_q[ch_in][wr_idx] <= data_in;
      head_q[ch_in]      <= wr_idx;
    end
  end

  // sequencer, accumulator and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      chs_q     <= '0;
      acc_q     <= '0;
      data_out  <= '0;
      ch_out    <= '0;
      valid_out <= 1'b0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      overrun   <= drop;
      unique case (state_q)
        IDLE: begin
        end
        MAC: begin
          if (last) begin
            data_out  <= res.val[OUT_W-1:0];
            sat       <= res.sat;
            ch_out    <= chs_q;
            valid_out <= 1'b1;
            state_q   <= IDLE;
          end else begin
            acc_q <= sum;
            tap_q <= tap_q + 1'b1;
          end
        end
      endcase
      if (accept) begin
        state_q <= MAC;
        tap_q   <= '0;
        acc_q   <= '0;
        chs_q   <= ch_in;
      end
    end
  end

endmodule

// File: doc/fir_mc.md
# fir_mc

Multichannel, time-multiplexed Q-format FIR filter with a single MAC, per-channel delay lines and a double-buffered coefficient bank. It is the parametrised successor to the single-channel `W` filter. It serves up to CH interleaved sample streams (e.g. reference-noise and error paths of the ANC loop) through one N-tap datapath. Coefficients can be rewritten while filtering; a swap takes effect only between samples, so no output ever mixes two coefficient sets.

## Interface
- `N`, 32: taps per channel (≥2).
- `CH`, 2: channels (≥1).
- `IN_W`, 32: input sample width, signed.
- `COEFF_W`, 32: coefficient width, signed.
- `OUT_W`, 32: output width, signed.
- `R_IN`, 31: input fractional bits.
- `R_COEFF`, 31: coefficient fractional bits.
- `R_OUT`, 31: output fractional bits.
- `ACC_W`, IN_W+COEFF_W+$clog2(N): accumulator width.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: sample strobe.
- `ch_in` in $clog2(CH) (min 1): channel of `data_in`.
- `data_in` in IN_W: sample.
- `ready_in` out 1: datapath can accept a sample this cycle.
- `coeff_wr_en` in 1: write shadow bank.
- `coeff_addr` in $clog2(N): tap index.
- `coeff_data` in COEFF_W: coefficient.
- `coeff_swap` in 1: request shadow→active swap (pulse).
- `data_out` out OUT_W: filtered sample.
- `ch_out` out $clog2(CH): channel of `data_out`.
- `valid_out` out 1: one-cycle output strobe.
- `sat` out 1: `data_out` was clipped; qualified by `valid_out`.
- `overrun` out 1: one-cycle pulse; `valid_in` was dropped.

## Operation
- FSM has two states, IDLE and MAC. `ready_in` = (IDLE) or (MAC and tap==N-1).
- Accept occurs when `valid_in && ready_in`. The sample is written to the channel's delay line at `head[ch]+1 mod N`, `head[ch]` advances, the accumulator clears, tap=0 and the state goes to MAC.
- MAC cycle k (0..N-1): acc += x[ch][(head−k) mod N] · c_active[k]. The product is full width (IN_W+COEFF_W) and accumulation is exact in ACC_W.
- Final MAC cycle: the output is computed from acc plus the last product. Apply arithmetic shift right by S = R_IN+R_COEFF−R_OUT with round-half-up (add 2^(S−1) before shifting). Then saturate to the signed OUT_W range. `sat` is set if clipping occurred.
- A simultaneous accept in the final MAC cycle restarts MAC back-to-back. Otherwise the FSM returns to IDLE.
- `valid_in` while `ready_in`=0: the sample is dropped, `overrun` pulses, and no state changes.
- Shadow writes are accepted in any state and never affect an in-flight computation.
- `coeff_swap` sets `swap_pend`. The swap executes on the first edge where the FSM is IDLE, or on the final MAC cycle. A sample accepted on that same edge uses the new bank. A write and swap in the same cycle: the write lands in shadow first, then the swap copies it.
- Channels are fully independent. `ch_in` ≥ CH is treated as an overrun (dropped, `overrun` pulses).

## Timing
- Latency: the accept edge is E0; `data_out`/`ch_out`/`valid_out`/`sat` are registered at edge E0+N.
- Throughput: one sample per N cycles.
- Reset (async, `reset_n`=0):
  - FSM goes to IDLE; `ready_in`=1 after release.
  - `valid_out`=0, `overrun`=0, `sat`=0, `data_out`=0, `ch_out`=0.
  - All delay lines, heads, both coefficient banks and `swap_pend` go to 0.
- Reset mid-computation aborts it; no `valid_out` is produced for the aborted sample.
- `valid_out` is never asserted on two consecutive cycles unless N=1 (excluded).

## Structure
- Package `fir_mc_pkg`:
  - FSM state enum.
  - `sat_round` function (shift, round, saturate; parametrised via widths passed as arguments, or localparams).
  - Helper for the $clog2(CH) minimum-1 width.
- Sub-module `fir_mc_coeff_bank`: shadow/active register banks, write port, `swap_pend`, swap strobe from the FSM, and a read port by tap index.
- Delay lines and MAC live in the top module.

## Test plan
- **Impulse, CH=1:** active bank = coefficients 1..32 (Q1.31 scaled by 2^-6); inject 0x7FFFFFFF then 31 zeros at K=N spacing → outputs reproduce c[0..31] in order, each out N cycles after its accept, `sat`=0.
- **Interleave, CH=2:** impulse on ch0, constant 0x40000000 on ch1, alternating → ch0 yields the coefficient sequence and ch1 yields the running sum; `ch_out` is correct and there is no cross-talk.
- **Saturation:** all coefficients 0x7FFFFFFF, input 0x7FFFFFFF steady → `data_out`=0x7FFFFFFF with `sat`=1. Repeat with input 0x80000000 → 0x80000000 and `sat`=1.
- **Swap mid-computation:** write a new bank and pulse `coeff_swap` at MAC tap 10 → the current output uses the old bank and the next accepted sample uses the new bank.
- **Overrun:** `valid_in` two cycles apart → second sample dropped, `overrun`=1 for one cycle, outputs unaffected.
- **Reset mid-MAC:** assert `reset_n`=0 at tap 15 → all outputs 0 immediately, no `valid_out`; after release the impulse test passes from clean state.
